// File: rtl/hazard_detection_unit_pkg.sv
// rtl/hazard_detection_unit_pkg.sv - shared state encoding, counter width and load-use helper
package hazard_detection_unit_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hdu_state_e;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  function automatic logic load_use_detect(
    input logic       mem_read_ex,
    input logic [4:0] rt_ex,
    input logic [4:0] rs_id,
    input logic [4:0] rt_id,
    input logic       uses_rt_id
  );
    return mem_read_ex && (rt_ex != 5'd0) &&
           ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// rtl/hazard_detection_unit_if.sv - pipeline hazard inputs and stage control outputs
interface hazard_detection_unit_if;
  import hazard_detection_unit_pkg::*;

  logic             ctrl_mem_read_id_ex;
  logic [4:0]       rt_id_ex;
  logic [4:0]       rs_if_id;
  logic [4:0]       rt_if_id;
  logic             uses_rt_if_id;
  logic             ctrl_jump;
  logic             branch_taken_ex_mem;
  logic             mem_access_ex_mem;
  logic             dmem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             ctrl_hazard_mux_hazard;
  logic             pipeline_freeze;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output ctrl_mem_read_id_ex, rt_id_ex, rs_if_id, rt_if_id, uses_rt_if_id,
           ctrl_jump, branch_taken_ex_mem, mem_access_ex_mem, dmem_ready,
    input  pc_write, if_id_write, ctrl_hazard_mux_hazard, pipeline_freeze,
           if_id_flush, id_ex_flush, ex_mem_flush, stall_cycles, flush_events
  );

  modport slave (
    input  ctrl_mem_read_id_ex, rt_id_ex, rs_if_id, rt_if_id, uses_rt_if_id,
           ctrl_jump, branch_taken_ex_mem, mem_access_ex_mem, dmem_ready,
    output pc_write, if_id_write, ctrl_hazard_mux_hazard, pipeline_freeze,
           if_id_flush, id_ex_flush, ex_mem_flush, stall_cycles, flush_events
  );

endinterface

// File: rtl/hazard_detection_unit_sat_counter16.sv
// rtl/hazard_detection_unit_sat_counter16.sv - enabled up-counter that sticks at all-ones
module sat_counter16
  import hazard_detection_unit_pkg::*;
(
  input  logic             clock,
  input  logic             clear_n,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - stall/flush control for a 5-stage pipeline
// Outputs are Mealy: they react to the current inputs in the same cycle.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  hazard_detection_unit_if.slave hif
);

  hdu_state_e state_q;
  hdu_state_e state_d;
  logic       load_use;
  logic       mem_stall;
  logic       stall_en;
  logic       flush_en;

  assign load_use  = load_use_detect(hif.ctrl_mem_read_id_ex, hif.rt_id_ex,
                                     hif.rs_if_id, hif.rt_if_id, hif.uses_rt_if_id);
  assign mem_stall = hif.mem_access_ex_mem && !hif.dmem_ready;

  always_comb begin
    hif.pc_write               = 1'b1;
    hif.if_id_write            = 1'b1;
    hif.ctrl_hazard_mux_hazard = 1'b0;
    hif.pipeline_freeze        = 1'b0;
    hif.if_id_flush            = 1'b0;
    hif.id_ex_flush            = 1'b0;
    hif.ex_mem_flush           = 1'b0;
    state_d                    = RUN;
    if (mem_stall) begin
      hif.pc_write        = 1'b0;
      hif.if_id_write     = 1'b0;
      hif.pipeline_freeze = 1'b1;
      state_d             = MEM_WAIT;
    end else if (hif.branch_taken_ex_mem) begin
      hif.if_id_flush  = 1'b1;
      hif.id_ex_flush  = 1'b1;
      hif.ex_mem_flush = 1'b1;
    end else if (load_use && (state_q != LOAD_STALL)) begin
      // the same load is already one stage further after one bubble
      hif.pc_write               = 1'b0;
      hif.if_id_write            = 1'b0;
      hif.ctrl_hazard_mux_hazard = 1'b1;
      state_d                    = LOAD_STALL;
    end else if (hif.ctrl_jump) begin
      hif.if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign stall_en = !hif.pc_write;
  assign flush_en = hif.if_id_flush || hif.id_ex_flush || hif.ex_mem_flush;

  sat_counter16 u_stall_cnt (
    .clock   (clock),
    .clear_n (reset_n),
    .enable  (stall_en),
    .count   (hif.stall_cycles)
  );

  sat_counter16 u_flush_cnt (
    .clock   (clock),
    .clear_n (reset_n),
    .enable  (flush_en),
    .count   (hif.flush_events)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - directed checks of stall, flush, priority and counter behaviour
module tb_hazard_detection_unit;
  import hazard_detection_unit_pkg::*;

  logic clock;
  logic reset_n;
  int   n_asserts;
  int   n_fail;

  hazard_detection_unit_if hif ();

  hazard_detection_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .hif     (hif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mem_read, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                       input logic [4:0] rt_id, input logic uses_rt, input logic jump,
                       input logic branch, input logic mem_access, input logic ready);
    hif.ctrl_mem_read_id_ex = mem_read;
    hif.rt_id_ex            = rt_ex;
    hif.rs_if_id            = rs_id;
    hif.rt_if_id            = rt_id;
    hif.uses_rt_if_id       = uses_rt;
    hif.ctrl_jump           = jump;
    hif.branch_taken_ex_mem = branch;
    hif.mem_access_ex_mem   = mem_access;
    hif.dmem_ready          = ready;
  endtask

  // advance past the next rising edge; checks then land mid-cycle
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, hif.pc_write, hif.if_id_write, hif.ctrl_hazard_mux_hazard,
              hif.pipeline_freeze, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush}, {25'd0, exp});
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    // control bits: pc_write, if_id_write, bubble, freeze, if_id_fl, id_ex_fl, ex_mem_fl
    chk_ctrl("reset_ctrl", 7'b1100000);
    chk("reset_stall_cnt", 32'(hif.stall_cycles), 32'd0);
    chk("reset_flush_cnt", 32'(hif.flush_events), 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(RUN));
    cyc();
    reset_n = 1'b1;

    // load rt=5 in EX, ID reads rs=5
    cyc();
    drive(1, 5, 5, 0, 0, 0, 0, 0, 1);
    #2 chk_ctrl("load_use_stall", 7'b0010000);
    cyc();
    chk("load_stall_state", 32'(dut.state_q), 32'(LOAD_STALL));
    #1 chk_ctrl("load_stall_masked", 7'b1100000);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("load_back_run", 32'(dut.state_q), 32'(RUN));
    chk("load_stall_cnt", 32'(hif.stall_cycles), 32'd1);

    // load to r0 never stalls
    drive(1, 0, 0, 0, 1, 0, 0, 0, 1);
    #1 chk_ctrl("r0_no_stall", 7'b1100000);
    cyc();
    chk_ctrl("r0_no_stall_2", 7'b1100000);
    chk("r0_stall_cnt", 32'(hif.stall_cycles), 32'd1);

    // rt match matters only when the ID instruction reads rt
    drive(1, 7, 3, 7, 0, 0, 0, 0, 1);
    #1 chk_ctrl("rt_unused_no_stall", 7'b1100000);
    drive(1, 7, 3, 7, 1, 0, 0, 0, 1);
    #1 chk_ctrl("rt_used_stall", 7'b0010000);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    chk("rt_stall_cnt", 32'(hif.stall_cycles), 32'd2);

    // three cycles of memory wait, then exit straight into a load-use stall
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk_ctrl("mem_wait_1", 7'b0001000);
    cyc();
    chk("mem_wait_state", 32'(dut.state_q), 32'(MEM_WAIT));
    chk_ctrl("mem_wait_2", 7'b0001000);
    cyc();
    chk_ctrl("mem_wait_3", 7'b0001000);
    cyc();
    chk("mem_wait_cnt", 32'(hif.stall_cycles), 32'd5);
    drive(1, 9, 9, 0, 0, 0, 0, 1, 1);
    #1 chk_ctrl("mem_exit_load_use", 7'b0010000);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("mem_exit_state", 32'(dut.state_q), 32'(LOAD_STALL));
    chk_ctrl("mem_exit_normal", 7'b1100000);
    chk("mem_exit_cnt", 32'(hif.stall_cycles), 32'd6);
    cyc();

    // taken branch beats load-use and jump
    drive(1, 4, 4, 0, 0, 1, 1, 0, 1);
    #1 chk_ctrl("branch_priority", 7'b1100111);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("branch_flush_cnt", 32'(hif.flush_events), 32'd1);
    chk("branch_state", 32'(dut.state_q), 32'(RUN));
    chk("branch_stall_cnt", 32'(hif.stall_cycles), 32'd6);

    // jump alone
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
    #1 chk_ctrl("jump_flush", 7'b1100100);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk_ctrl("jump_one_cycle", 7'b1100000);
    chk("jump_flush_cnt", 32'(hif.flush_events), 32'd2);

    // memory stall masks a taken branch; hold long enough to saturate
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    #1 chk_ctrl("mem_over_branch", 7'b0001000);
    repeat (70000) @(posedge clock);
    #2 chk("stall_saturated", 32'(hif.stall_cycles), 32'h0000FFFF);
    chk("flush_cnt_held", 32'(hif.flush_events), 32'd2);
    chk("long_wait_state", 32'(dut.state_q), 32'(MEM_WAIT));
    @(posedge clock);
    #2 chk("stall_no_wrap", 32'(hif.stall_cycles), 32'h0000FFFF);

    // asynchronous reset mid-wait
    reset_n = 1'b0;
    #1 chk("async_rst_stall_cnt", 32'(hif.stall_cycles), 32'd0);
    chk("async_rst_flush_cnt", 32'(hif.flush_events), 32'd0);
    chk("async_rst_state", 32'(dut.state_q), 32'(RUN));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk_ctrl("async_rst_ctrl", 7'b1100000);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk_ctrl("post_rst_ctrl", 7'b1100000);
    chk("post_rst_stall_cnt", 32'(hif.stall_cycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
